// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg: shared widths, flush-length bound and FSM encoding for the MAC feeder.
package mac_feeder_pkg;
   localparam int ROW_W_DEF  = 10;
   localparam int COL_W_DEF  = 10;
   localparam int DATA_W_DEF = 64;
   localparam int DONE_MIN   = 129;
   typedef enum logic [2:0] {IDLE, STREAM, FLUSHPIPE, DRAIN, FIN} state_t;
endpackage

// File: rtl/mac_feeder_vec_ram.sv
// mac_feeder_vec_ram: simple dual-port vector RAM with a registered read port (BRAM friendly).
module mac_feeder_vec_ram #(
   parameter int AW = 10,
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] rd_data
);
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rd_q;
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      rd_q <= mem[ra];
   end
   assign rd_data = rd_q;
endmodule

// File: rtl/mac_feeder.sv
// mac_feeder: streams sparse nonzeros with x[col] lookups into the MAC accumulator, then drives the flush.
module mac_feeder
   import mac_feeder_pkg::*;
#(
   parameter int ROW_W       = ROW_W_DEF,
   parameter int COL_W       = COL_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int DONE_CYCLES = 200
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              vec_wr,
   input  logic [COL_W-1:0]  vec_addr,
   input  logic [DATA_W-1:0] vec_data,
   input  logic              nz_valid,
   output logic              nz_ready,
   input  logic [ROW_W-1:0]  nz_row,
   input  logic [COL_W-1:0]  nz_col,
   input  logic [DATA_W-1:0] nz_value,
   input  logic              nz_last,
   output logic              mac_wr,
   output logic [ROW_W-1:0]  mac_row,
   output logic [DATA_W-1:0] mac_value0,
   output logic [DATA_W-1:0] mac_value1,
   output logic              mac_done,
   output logic              busy,
   output logic              complete,
   output logic [31:0]       nz_count,
   output logic              err
);
   // the accumulator flushes at done-count 128 and wraps at 256, so keep the hold inside that window
   localparam int DONE_N = DONE_CYCLES < DONE_MIN ? DONE_MIN : (DONE_CYCLES > 255 ? 255 : DONE_CYCLES);
   localparam logic [7:0] DONE_LAST = 8'(DONE_N - 1);

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                s1_v_q, s1_v_d;
   logic [ROW_W-1:0]    s1_row_q, s1_row_d;
   logic [DATA_W-1:0]   s1_val_q, s1_val_d;
   logic                mac_wr_q, mac_wr_d;
   logic [ROW_W-1:0]    mac_row_q, mac_row_d;
   logic [DATA_W-1:0]   mac_value0_q, mac_value0_d;
   logic [DATA_W-1:0]   mac_value1_q, mac_value1_d;
   logic [31:0]         nz_count_q, nz_count_d;
   logic                err_q, err_d;
   logic                accept;
   logic [DATA_W-1:0]   rd_data;

   assign accept = nz_valid & nz_ready;

   mac_feeder_vec_ram #(.AW(COL_W), .DW(DATA_W)) u_vec_ram (
      .clk     (clk),
      .we      (vec_wr && state_q != STREAM),
      .wa      (vec_addr),
      .wd      (vec_data),
      .ra      (nz_col),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      s1_v_d       = accept;
      s1_row_d     = accept ? nz_row : s1_row_q;
      s1_val_d     = accept ? nz_value : s1_val_q;
      mac_wr_d     = s1_v_q;
      mac_row_d    = s1_v_q ? s1_row_q : mac_row_q;
      mac_value0_d = s1_v_q ? s1_val_q : mac_value0_q;
      mac_value1_d = s1_v_q ? rd_data : mac_value1_q;
      nz_count_d   = s1_v_q ? nz_count_q + 32'd1 : nz_count_q;
      err_d        = err_q | (vec_wr & (state_q == STREAM));
      case (state_q)
         IDLE: if (start) begin
            state_d    = STREAM;
            nz_count_d = '0;
         end
         STREAM: if (accept && nz_last) state_d = FLUSHPIPE;
         FLUSHPIPE: if (!s1_v_q && !mac_wr_q) begin
            state_d = DRAIN;
            cnt_d   = '0;
         end
         DRAIN: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == DONE_LAST) state_d = FIN;
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         s1_v_q       <= 1'b0;
         s1_row_q     <= '0;
         s1_val_q     <= '0;
         mac_wr_q     <= 1'b0;
         mac_row_q    <= '0;
         mac_value0_q <= '0;
         mac_value1_q <= '0;
         nz_count_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         s1_v_q       <= s1_v_d;
         s1_row_q     <= s1_row_d;
         s1_val_q     <= s1_val_d;
         mac_wr_q     <= mac_wr_d;
         mac_row_q    <= mac_row_d;
         mac_value0_q <= mac_value0_d;
         mac_value1_q <= mac_value1_d;
         nz_count_q   <= nz_count_d;
         err_q        <= err_d;
      end
   end

   assign nz_ready   = state_q == STREAM;
   assign mac_done   = state_q == DRAIN;
   assign busy       = state_q != IDLE;
   assign complete   = state_q == FIN;
   assign mac_wr     = mac_wr_q;
   assign mac_row    = mac_row_q;
   assign mac_value0 = mac_value0_q;
   assign mac_value1 = mac_value1_q;
   assign nz_count   = nz_count_q;
   assign err        = err_q;
endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Initiator for the sparse multiply-accumulate unit: holds a dense vector x in on-chip RAM and accepts a stream of matrix nonzeros (row, col, value).
- For each nonzero it looks up x[col] and drives mac_row/mac_value0/mac_value1/mac_wr.
- After the last nonzero it holds mac_done high long enough for the accumulator to flush, then reports completion.
- Sits between the nonzero decode/memory front end and the accumulator.

Parameters:
ROW_W, 10, row index width (matches accumulator row port)
COL_W, 10, column index width; vector RAM depth = 2**COL_W
DATA_W, 64, IEEE double operand width
DONE_CYCLES, 200, cycles mac_done is held; must be >=129 and <=255 (accumulator flushes at done-count 128 and wraps at 256)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse in IDLE begins a multiply pass
vec_wr  in  1  vector RAM write strobe
vec_addr  in  COL_W  vector RAM write address
vec_data  in  DATA_W  vector RAM write data
nz_valid  in  1  nonzero available
nz_ready  out  1  feeder accepts nonzero this cycle
nz_row  in  ROW_W  nonzero row
nz_col  in  COL_W  nonzero column
nz_value  in  DATA_W  nonzero value
nz_last  in  1  final nonzero of the pass
mac_wr  out  1  product request to accumulator
mac_row  out  ROW_W  row tag
mac_value0  out  DATA_W  matrix value
mac_value1  out  DATA_W  x[col]
mac_done  out  1  flush request to accumulator
busy  out  1  state != IDLE
complete  out  1  one-cycle pulse at end of pass
nz_count  out  32  nonzeros issued in current/last pass
err  out  1  sticky: vec_wr seen during STREAM

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; pipeline valids cleared; nz_count 0; err 0. Vector RAM contents are not cleared.
- States:
  - IDLE: start -> STREAM; clear nz_count on entry to STREAM.
  - STREAM: nz_ready = 1 until a beat with nz_last is accepted, then 0.
  - FLUSHPIPE: wait until both pipeline stages are empty.
  - DRAIN: mac_done = 1 for exactly DONE_CYCLES cycles.
  - FIN: complete = 1 for one cycle, then -> IDLE.
- start outside IDLE is ignored.
- Accept = nz_valid & nz_ready.
  - Edge k (accept): RAM read address = nz_col; row and value are registered.
  - Edge k+1: RAM data plus the registered fields enter the output registers.
  - mac_wr is high during the cycle following edge k+1. Latency is 2 cycles, fixed.
  - Back-to-back accepts give back-to-back mac_wr; no bubbles inserted.
- mac_wr = 0 in all non-issue cycles. mac_row/mac_value* hold their last values when mac_wr = 0.
- nz_count increments on every mac_wr and wraps at 2**32.
- Vector writes:
  - Accepted in IDLE, FLUSHPIPE, DRAIN and FIN; 1-cycle write.
  - A same-address read issued in the same cycle returns the old data.
  - vec_wr in STREAM is dropped and sets err. err clears only on reset.
- A pass with no nonzeros: start followed immediately by an nz_last beat still issues that beat (nz_last always carries a valid nonzero).
- Reset mid-pass: pipeline is abandoned and mac_done drops at once. The accumulator must be reset with it.

Decomposition:
- Shared package: ROW_W/COL_W/DATA_W defaults, state encoding, DONE_CYCLES minimum constant (129).
- One sub-module: vec_ram (simple dual-port, 1-cycle registered read, write-first not required) so it can map to BRAM.

Test Plan:
- Load x[3]=0x4000000000000000 (2.0) in IDLE, start, send one nonzero {row=5, col=3, value=0x3FF8000000000000 (1.5), last=1} -> one mac_wr exactly 2 cycles after accept with row=5, value0=1.5, value1=2.0; mac_done high 200 cycles; complete pulse; nz_count=1.
- Stream 64 back-to-back nonzeros with col=i, valid held high -> 64 consecutive mac_wr cycles, each value1=x[i], order preserved, nz_count=64.
- Toggle nz_valid randomly on a 20-nonzero pass -> mac_wr pattern equals accept pattern delayed 2 cycles; nz_ready drops the cycle after the nz_last accept.
- vec_wr during STREAM to addr 7 -> RAM[7] unchanged on later read, err=1 and stays 1; busy unaffected.
- Assert reset while 2 requests are in the pipeline and mac_done is low -> all outputs 0 asynchronously, state IDLE, no mac_wr after reset release; a following start runs normally.
- start pulsed during DRAIN -> ignored; exactly one complete pulse, then IDLE.
